serial_frame_tx: RTL and testbench

SERIAL_FRAME_TX -- requirements
Module: serial_frame_tx

---
 rtl/serial_frame_tx.sv | 176 +++++++++++++++++
 tb/tb_serial_frame_tx.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: serialises one frame per accepted request onto serOut.
// Frame: start bit 0, port_addr[3:0], line_sel[1:0], size_chunk[5:0] (all MSB
// first), then payload[N-1:0] MSB first, followed by GAP_CYCLES idle-high
// cycles and a one-cycle done pulse.
// Ports:
//   clk        - rising-edge clock
//   rst        - asynchronous active-high reset
//   start      - frame request, accepted in IDLE (or DONE, for back-to-back)
//   port_addr  - destination port (4 bits)
//   line_sel   - destination line (2 bits)
//   size_chunk - payload length N in bits (0..63)
//   payload    - payload data, bits [N-1:0] sent
//   serOut     - registered serial output, idle high
//   busy       - high while a frame or its gap is on the line
//   done       - one-cycle pulse after the gap
module serial_frame_tx #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [3:0]  port_addr,
  input  logic [1:0]  line_sel,
  input  logic [5:0]  size_chunk,
  input  logic [62:0] payload,
  output logic        serOut,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_SIZE  = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [2:0]  addr_cnt_q, addr_cnt_d;
  logic [5:0]  bit_cnt_q, bit_cnt_d;
  logic [3:0]  gap_cnt_q, gap_cnt_d;
  logic [3:0]  port_q, port_d;
  logic [1:0]  line_q, line_d;
  logic [5:0]  size_q, size_d;
  logic [62:0] payload_q, payload_d;
  logic        serout_q, serout_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        enter_gap;
  logic        accept;
  logic [5:0]  hdr;

  // Next-state logic; outputs are decoded from the next state so that each
  // bit is registered and appears in the cycle its state is occupied.
  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    port_d     = port_q;
    line_d     = line_q;
    size_d     = size_q;
    payload_d  = payload_q;
    enter_gap  = 1'b0;
    accept     = 1'b0;
    hdr        = {port_q, line_q};

    case (state_q)
      S_IDLE: begin
        if (start) accept = 1'b1;
      end
      S_START: begin
        state_d    = S_ADDR;
        addr_cnt_d = 3'd5;
      end
      S_ADDR: begin
        if (addr_cnt_q == 3'd0) begin
          state_d   = S_SIZE;
          bit_cnt_d = 6'd5;
        end else begin
          addr_cnt_d = addr_cnt_q - 3'd1;
        end
      end
      S_SIZE: begin
        if (bit_cnt_q == 6'd0) begin
          if (size_q != 6'd0) begin
            state_d   = S_DATA;
            bit_cnt_d = size_q - 6'd1;
          end else begin
            enter_gap = 1'b1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q - 6'd1;
        end
      end
      S_DATA: begin
        if (bit_cnt_q == 6'd0) enter_gap = 1'b1;
        else                   bit_cnt_d = bit_cnt_q - 6'd1;
      end
      S_GAP: begin
        if (gap_cnt_q == 4'd0) state_d = S_DONE;
        else                   gap_cnt_d = gap_cnt_q - 4'd1;
      end
      S_DONE: begin
        // A start held through DONE chains straight into the next frame.
        if (start) accept = 1'b1;
        else       state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_gap) begin
      if (GAP_CYCLES == 0) begin
        state_d = S_DONE;
      end else begin
        state_d   = S_GAP;
        gap_cnt_d = 4'(GAP_CYCLES - 1);
      end
    end

    if (accept) begin
      state_d   = S_START;
      port_d    = port_addr;
      line_d    = line_sel;
      size_d    = size_chunk;
      payload_d = payload;
    end

    serout_d = 1'b1;
    case (state_d)
      S_START: serout_d = 1'b0;
      S_ADDR:  serout_d = hdr[addr_cnt_d];
      S_SIZE:  serout_d = size_q[bit_cnt_d[2:0]];
      S_DATA:  serout_d = payload_q[bit_cnt_d];
      default: serout_d = 1'b1;
    endcase

    busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
    done_d = (state_d == S_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_cnt_q <= 3'd0;
      bit_cnt_q  <= 6'd0;
      gap_cnt_q  <= 4'd0;
      port_q     <= 4'd0;
      line_q     <= 2'd0;
      size_q     <= 6'd0;
      payload_q  <= 63'd0;
      serout_q   <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      port_q     <= port_d;
      line_q     <= line_d;
      size_q     <= size_d;
      payload_q  <= payload_d;
      serout_q   <= serout_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign serOut = serout_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_serial_frame_tx.sv
// Testbench for serial_frame_tx: builds each expected frame as a bit list
// from the request fields and compares serOut/busy/done cycle by cycle.
module tb_serial_frame_tx;

  localparam int unsigned GAP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [3:0]  port_addr;
  logic [1:0]  line_sel;
  logic [5:0]  size_chunk;
  logic [62:0] payload;
  logic        serOut;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  // Next-frame fields for a start held through DONE.
  bit          hold_next = 1'b0;
  logic [3:0]  nxt_p;
  logic [1:0]  nxt_l;
  logic [5:0]  nxt_n;
  logic [62:0] nxt_pl;

  serial_frame_tx #(.GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .port_addr  (port_addr),
    .line_sel   (line_sel),
    .size_chunk (size_chunk),
    .payload    (payload),
    .serOut     (serOut),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic [3:0] p, input logic [1:0] l, input logic [5:0] n,
                       input logic [62:0] pl);
    port_addr  = p;
    line_sel   = l;
    size_chunk = n;
    payload    = pl;
    start      = 1'b1;
  endtask

  task automatic scramble();
    port_addr  = 4'($urandom);
    line_sel   = 2'($urandom);
    size_chunk = 6'($urandom);
    payload    = {31'($urandom), 32'($urandom)};
    start      = 1'($urandom);
  endtask

  function automatic logic [62:0] rand_pl();
    return {31'($urandom), 32'($urandom)};
  endfunction

  // Send one frame and check every cycle from the start bit through done.
  // chained: request already on the inputs (accepted at the next edge).
  // abort_at: cycle index at which reset is asserted (-1 for none).
  task automatic send(input logic [3:0] p, input logic [1:0] l, input logic [5:0] n,
                      input logic [62:0] pl, input bit rnd, input bit chained,
                      input int abort_at);
    bit          exp_bits[$];
    int          total;
    logic [12:0] hdr;
    if (!chained) begin
      @(negedge clk);
      drive(p, l, n, pl);
    end
    @(posedge clk);
    hdr = {1'b0, p, l, n};
    for (int k = 12; k >= 0; k--) exp_bits.push_back(hdr[k]);
    for (int k = int'(n) - 1; k >= 0; k--) exp_bits.push_back(pl[k]);
    for (int k = 0; k < int'(GAP); k++) exp_bits.push_back(1'b1);
    total = exp_bits.size() + 1;
    for (int i = 0; i < total; i++) begin
      @(negedge clk);
      if (i < total - 1) begin
        check("serOut", {63'd0, serOut}, {63'd0, exp_bits[i]});
        check("busy", {63'd0, busy}, 64'd1);
        check("done", {63'd0, done}, 64'd0);
      end else begin
        check("serOut_done", {63'd0, serOut}, 64'd1);
        check("busy_done", {63'd0, busy}, 64'd0);
        check("done_pulse", {63'd0, done}, 64'd1);
      end
      if (i == abort_at) begin
        #1 rst = 1'b1;
        #1;
        check("abort_serOut", {63'd0, serOut}, 64'd1);
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        return;
      end
      if (i < total - 1) begin
        if (rnd) scramble();
        else     start = 1'b0;
      end else if (hold_next) begin
        drive(nxt_p, nxt_l, nxt_n, nxt_pl);
      end else begin
        start = 1'b0;
      end
    end
  endtask

  initial begin
    logic [3:0]  p;
    logic [1:0]  l;
    logic [5:0]  n;
    rst        = 1'b1;
    start      = 1'b0;
    port_addr  = 4'd0;
    line_sel   = 2'd0;
    size_chunk = 6'd0;
    payload    = 63'd0;
    repeat (2) @(negedge clk);
    check("rst_serOut", {63'd0, serOut}, 64'd1);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);

    // Directed frame, accepted on the first edge after reset release.
    rst = 1'b0;
    drive(4'b1010, 2'b01, 6'd5, 63'b11001);
    send(4'b1010, 2'b01, 6'd5, 63'b11001, 1'b0, 1'b1, -1);

    // Empty payload; stray payload bits must be ignored.
    send(4'd0, 2'd3, 6'd0, rand_pl(), 1'b0, 1'b0, -1);

    // Maximum payload, all ones except bit 0.
    send(4'h5, 2'd2, 6'd63, 63'h7FFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, -1);

    // Random starts mid-frame, then start held through DONE.
    hold_next = 1'b1;
    nxt_p     = 4'h9;
    nxt_l     = 2'd2;
    nxt_n     = 6'd7;
    nxt_pl    = rand_pl();
    send(4'h3, 2'd1, 6'd12, rand_pl(), 1'b1, 1'b0, -1);
    hold_next = 1'b0;
    send(nxt_p, nxt_l, nxt_n, nxt_pl, 1'b0, 1'b1, -1);

    // Reset during data bit 3 (cycle 13 is the first data bit).
    send(4'hC, 2'd0, 6'd10, rand_pl(), 1'b0, 1'b0, 16);
    start = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("rst_hold_done", {63'd0, done}, 64'd0);
      check("rst_hold_serOut", {63'd0, serOut}, 64'd1);
    end
    rst = 1'b0;
    p = 4'h6;
    l = 2'd3;
    n = 6'd9;
    nxt_pl = rand_pl();
    drive(p, l, n, nxt_pl);
    send(p, l, n, nxt_pl, 1'b0, 1'b1, -1);

    // Randomized frames, half with inputs scrambled every busy cycle.
    for (int f = 0; f < 12; f++) begin
      p = 4'($urandom);
      l = 2'($urandom);
      case (f % 4)
        0:       n = 6'd0;
        1:       n = 6'd63;
        default: n = 6'($urandom_range(1, 62));
      endcase
      send(p, l, n, rand_pl(), bit'(f % 2), 1'b0, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
